// File: rtl/mul_iterative_xunit.sv
// Iterative shift-add RV32 MUL execute pipe: one instruction in flight, 2+N cycles from accept to result.
// Result held on W_* until accepted by writeback; D_rdy only in IDLE, so no same-cycle refill.
module mul_iterative_xunit #(
    parameter int p_seq_num_bits = 5,
    parameter bit p_early_exit   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      D_val,
    output logic                      D_rdy,
    input  logic [31:0]               D_pc,
    input  logic [31:0]               D_op1,
    input  logic [31:0]               D_op2,
    input  logic [4:0]                D_waddr,
    input  logic [p_seq_num_bits-1:0] D_seq_num,
    output logic                      W_val,
    input  logic                      W_rdy,
    output logic [31:0]               W_pc,
    output logic [p_seq_num_bits-1:0] W_seq_num,
    output logic [4:0]                W_waddr,
    output logic [31:0]               W_wdata,
    output logic                      W_wen
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                    state, state_next;
    logic [31:0]               a, b, acc;
    logic [5:0]                cnt;
    logic [31:0]               pc;
    logic [4:0]                waddr;
    logic [p_seq_num_bits-1:0] seq_num;

    logic d_xfer, w_xfer, calc_done;

    assign d_xfer    = D_val & D_rdy;
    assign w_xfer    = W_val & W_rdy;
    // Once the remaining multiplier is zero, further iterations add nothing.
    assign calc_done = (p_early_exit && (b == 32'd0)) || (cnt == 6'd32);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (d_xfer)    state_next = CALC;
            CALC:    if (calc_done) state_next = DONE;
            DONE:    if (w_xfer)    state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    always_comb begin
        D_rdy = (state == IDLE) && !rst;
        W_val = (state == DONE) && !rst;
        W_wen = W_val;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 6'd0;
            acc <= 32'd0;
        end else if (d_xfer) begin
            a       <= D_op1;
            b       <= D_op2;
            acc     <= 32'd0;
            cnt     <= 6'd0;
            pc      <= D_pc;
            waddr   <= D_waddr;
            seq_num <= D_seq_num;
        end else if (state == CALC && !calc_done) begin
            acc <= acc + (b[0] ? a : 32'd0);
            a   <= a << 1;
            b   <= b >> 1;
            cnt <= cnt + 6'd1;
        end
    end

    assign W_pc      = pc;
    assign W_seq_num = seq_num;
    assign W_waddr   = waddr;
    assign W_wdata   = acc;

endmodule

// File: tb/tb_mul_iterative_xunit.sv
// Randomized bench for mul_iterative_xunit: instance 0 uses early exit, instance 1 always runs 32 iterations.
module tb_mul_iterative_xunit;

    logic        clk = 1'b0;
    logic        rst;
    logic        d_val   [2];
    logic        d_rdy   [2];
    logic [31:0] d_pc    [2];
    logic [31:0] d_op1   [2];
    logic [31:0] d_op2   [2];
    logic [4:0]  d_waddr [2];
    logic [4:0]  d_seq   [2];
    logic        w_val   [2];
    logic        w_rdy   [2];
    logic [31:0] w_pc    [2];
    logic [4:0]  w_seq   [2];
    logic [4:0]  w_waddr [2];
    logic [31:0] w_wdata [2];
    logic        w_wen   [2];

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_data, exp_pc;
    logic [4:0]  exp_waddr, exp_seq;
    int          exp_lat;

    always #5 clk = ~clk;

    mul_iterative_xunit #(.p_seq_num_bits(5), .p_early_exit(1'b1)) u_dut0 (
        .clk(clk), .rst(rst),
        .D_val(d_val[0]), .D_rdy(d_rdy[0]), .D_pc(d_pc[0]), .D_op1(d_op1[0]), .D_op2(d_op2[0]),
        .D_waddr(d_waddr[0]), .D_seq_num(d_seq[0]),
        .W_val(w_val[0]), .W_rdy(w_rdy[0]), .W_pc(w_pc[0]), .W_seq_num(w_seq[0]),
        .W_waddr(w_waddr[0]), .W_wdata(w_wdata[0]), .W_wen(w_wen[0])
    );

    mul_iterative_xunit #(.p_seq_num_bits(5), .p_early_exit(1'b0)) u_dut1 (
        .clk(clk), .rst(rst),
        .D_val(d_val[1]), .D_rdy(d_rdy[1]), .D_pc(d_pc[1]), .D_op1(d_op1[1]), .D_op2(d_op2[1]),
        .D_waddr(d_waddr[1]), .D_seq_num(d_seq[1]),
        .W_val(w_val[1]), .W_rdy(w_rdy[1]), .W_pc(w_pc[1]), .W_seq_num(w_seq[1]),
        .W_waddr(w_waddr[1]), .W_wdata(w_wdata[1]), .W_wen(w_wen[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Iterations needed: position of the highest set multiplier bit, or always 32 without early exit.
    function automatic int n_iters(input bit early, input logic [31:0] v);
        int n = 0;
        if (!early) return 32;
        while (v != 32'd0) begin
            n++;
            v = v >> 1;
        end
        return n;
    endfunction

    task automatic xfer(input int u, input logic [31:0] op1, input logic [31:0] op2);
        int waited = 0;
        logic [63:0] prod;
        @(negedge clk);
        while (!d_rdy[u] && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        chk("d_rdy_wait", 32'(d_rdy[u]), 32'd1);
        d_val[u]   = 1'b1;
        d_op1[u]   = op1;
        d_op2[u]   = op2;
        d_pc[u]    = $urandom & 32'hFFFF_FFFC;
        d_waddr[u] = 5'($urandom);
        d_seq[u]   = 5'($urandom);
        prod       = 64'(op1) * 64'(op2);
        exp_data   = prod[31:0];
        exp_pc     = d_pc[u];
        exp_waddr  = d_waddr[u];
        exp_seq    = d_seq[u];
        exp_lat    = 2 + n_iters(u == 0, op2);
        @(posedge clk);
        #1;
        d_val[u] = 1'b0;
        d_op1[u] = $urandom;
        d_op2[u] = $urandom;
        d_pc[u]  = $urandom;
    endtask

    task automatic collect(input int u, input int stall);
        int lat = 1;
        w_rdy[u] = (stall == 0);
        @(negedge clk);
        while (!w_val[u] && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("wdata", w_wdata[u], exp_data);
        chk("waddr", 32'(w_waddr[u]), 32'(exp_waddr));
        chk("pc", w_pc[u], exp_pc);
        chk("seq_num", 32'(w_seq[u]), 32'(exp_seq));
        chk("wen", 32'(w_wen[u]), 32'd1);
        chk("d_rdy_done", 32'(d_rdy[u]), 32'd0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("hold_wval", 32'(w_val[u]), 32'd1);
            chk("hold_wdata", w_wdata[u], exp_data);
            chk("hold_pc", w_pc[u], exp_pc);
            chk("hold_waddr", 32'(w_waddr[u]), 32'(exp_waddr));
            chk("hold_drdy", 32'(d_rdy[u]), 32'd0);
        end
        w_rdy[u] = 1'b1;
        @(posedge clk);
        #1;
        w_rdy[u] = 1'b0;
        @(negedge clk);
        chk("post_wval", 32'(w_val[u]), 32'd0);
        chk("post_drdy", 32'(d_rdy[u]), 32'd1);
    endtask

    task automatic run_op(input int u, input logic [31:0] op1, input logic [31:0] op2, input int stall);
        xfer(u, op1, op2);
        collect(u, stall);
    endtask

    initial begin
        rst = 1'b1;
        for (int u = 0; u < 2; u++) begin
            d_val[u] = 1'b0; w_rdy[u] = 1'b0; d_pc[u] = '0; d_op1[u] = '0;
            d_op2[u] = '0; d_waddr[u] = '0; d_seq[u] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_drdy0", 32'(d_rdy[0]), 32'd0);
        chk("rst_wval0", 32'(w_val[0]), 32'd0);
        chk("rst_drdy1", 32'(d_rdy[1]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_drdy0", 32'(d_rdy[0]), 32'd1);
        chk("idle_drdy1", 32'(d_rdy[1]), 32'd1);
        chk("idle_wval0", 32'(w_val[0]), 32'd0);

        run_op(0, 32'd7, 32'd6, 0);
        run_op(0, 32'hDEAD_BEEF, 32'd0, 0);
        run_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(1, 32'd3, 32'd1, 0);
        run_op(0, $urandom, $urandom, 10);

        // Reset while iterating: the instruction must vanish without reaching writeback.
        xfer(0, 32'h1234_5678, 32'hFFFF_0000);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_drdy", 32'(d_rdy[0]), 32'd0);
        @(negedge clk);
        chk("midrst_wval", 32'(w_val[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_wval", 32'(w_val[0]), 32'd0);
        chk("postrst_drdy", 32'(d_rdy[0]), 32'd1);
        run_op(0, 32'd2, 32'd5, 0);

        for (int i = 0; i < 40; i++) begin
            int u;
            logic [31:0] op2;
            u   = int'($urandom_range(0, 1));
            op2 = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 7) == 0) op2 = 32'd0;
            run_op(u, $urandom, op2, int'($urandom_range(0, 3)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
